// File: rtl/texture_fetch_arbiter.sv
// Round-robin arbiter for the texture tile memory read port, with latency tracking and a credit-protected response FIFO.
// Optional grant/stall statistics counters are enabled by defining TEX_ARB_STATS_EN.
module texture_fetch_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int READ_LATENCY = 2,
    parameter int RSP_DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    output logic [NUM_REQ-1:0]   o_req_ready,
    input  logic [NUM_REQ*8-1:0] i_req_idx,
    input  logic                 i_upload_busy,
    output logic [7:0]           o_tex_idx,
    input  logic [2047:0]        i_tex_data,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [2047:0]        o_rsp_data,
    output logic [ID_W-1:0]      o_rsp_id,
    output logic                 o_busy
`ifdef TEX_ARB_STATS_EN
    ,
    output logic [31:0]          o_grant_cnt,
    output logic [31:0]          o_stall_cnt
`endif
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [7:0]              tex_idx_q, tex_idx_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [ID_W-1:0]         pipe_id_q [READ_LATENCY];
    logic [ID_W-1:0]         pipe_id_d [READ_LATENCY];
    logic [2047:0]           fifo_data_q [RSP_DEPTH];
    logic [2047:0]           fifo_data_d [RSP_DEPTH];
    logic [ID_W-1:0]         fifo_id_q [RSP_DEPTH];
    logic [ID_W-1:0]         fifo_id_d [RSP_DEPTH];
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    logic                    can_grant, grant, gnt_found, push, pop;
    logic [ID_W-1:0]         gnt_id, cand;
    logic [7:0]              sel_idx;
    int                      inflight;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every outstanding read and every queued response holds one credit, so captures never overflow the FIFO.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + int'(pipe_vld_q[i]);
        end
        can_grant = rst_n && !i_upload_busy && ((inflight + int'(count_q)) < RSP_DEPTH);
    end

    always_comb begin
        gnt_found   = 1'b0;
        gnt_id      = '0;
        cand        = '0;
        sel_idx     = '0;
        o_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!gnt_found && i_req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                sel_idx = i_req_idx[8*k +: 8];
            end
        end
        grant = can_grant && gnt_found;
        if (grant) begin
            o_req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        tex_idx_d = tex_idx_q;
        if (grant) begin
            ptr_d     = ID_W'((int'(gnt_id) + 1) % NUM_REQ);
            tex_idx_d = sel_idx;
        end
        pipe_vld_d    = '0;
        pipe_vld_d[0] = grant;
        pipe_id_d[0]  = gnt_id;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
    end

    // First-word fall-through FIFO; the head entry is always visible on the response outputs.
    always_comb begin
        push        = pipe_vld_q[READ_LATENCY-1];
        pop         = (count_q != '0) && i_rsp_ready;
        fifo_data_d = fifo_data_q;
        fifo_id_d   = fifo_id_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = i_tex_data;
            fifo_id_d[wr_ptr_q]   = pipe_id_q[READ_LATENCY-1];
            wr_ptr_d              = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            tex_idx_q  <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_id_q[i] <= '0;
            end
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_id_q[i]   <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tex_idx_q   <= tex_idx_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_id_q   <= pipe_id_d;
            fifo_data_q <= fifo_data_d;
            fifo_id_q   <= fifo_id_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign o_tex_idx   = tex_idx_q;
    assign o_rsp_valid = (count_q != '0);
    assign o_rsp_data  = fifo_data_q[rd_ptr_q];
    assign o_rsp_id    = fifo_id_q[rd_ptr_q];
    assign o_busy      = (pipe_vld_q != '0) || o_rsp_valid;

`ifdef TEX_ARB_STATS_EN
    logic [31:0] grant_cnt_q, grant_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q + 32'(grant);
        stall_cnt_d = stall_cnt_q + 32'((|i_req_valid) && !grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_grant_cnt = grant_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_texture_fetch_arbiter.sv
// Randomized bench for texture_fetch_arbiter, checked against a transaction-level queue model of grants and responses.
module tb_texture_fetch_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int ID_W         = 2;
    localparam int READ_LATENCY = 2;
    localparam int RSP_DEPTH    = 2;
    localparam int MI           = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   i_req_valid;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic [NUM_REQ*8-1:0] i_req_idx;
    logic                 i_upload_busy;
    logic [7:0]           o_tex_idx;
    logic [2047:0]        i_tex_data;
    logic                 o_rsp_valid;
    logic                 i_rsp_ready;
    logic [2047:0]        o_rsp_data;
    logic [ID_W-1:0]      o_rsp_id;
    logic                 o_busy;
`ifdef TEX_ARB_STATS_EN
    logic [31:0]          o_grant_cnt;
    logic [31:0]          o_stall_cnt;
`endif

    texture_fetch_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .READ_LATENCY(READ_LATENCY), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_idx(i_req_idx),
        .i_upload_busy(i_upload_busy), .o_tex_idx(o_tex_idx), .i_tex_data(i_tex_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
        .o_rsp_id(o_rsp_id), .o_busy(o_busy)
`ifdef TEX_ARB_STATS_EN
        , .o_grant_cnt(o_grant_cnt), .o_stall_cnt(o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory read port model: the tile for an index is that index replicated across the whole line.
    logic [7:0] mem_pipe [4];
    always @(posedge clk) begin
        mem_pipe[0] <= o_tex_idx;
        for (int i = 1; i < 4; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign i_tex_data = {256{(READ_LATENCY == 1) ? o_tex_idx : mem_pipe[MI]}};

    typedef struct { int id; logic [7:0] idx; int due; } flight_t;
    typedef struct { int id; logic [7:0] idx; } rsp_t;

    flight_t    m_fl[$];
    rsp_t       m_rsp[$];
    int         m_ptr, m_grants, m_stalls, cyc;
    logic [7:0] m_last_idx;
    bit         req_vld [NUM_REQ];
    logic [7:0] req_idx_a [NUM_REQ];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        m_fl.delete();
        m_rsp.delete();
        m_ptr      = 0;
        m_last_idx = 8'h00;
        m_grants   = 0;
        m_stalls   = 0;
    endtask

    task automatic packInputs();
        for (int k = 0; k < NUM_REQ; k++) begin
            i_req_valid[k]       = req_vld[k];
            i_req_idx[8*k +: 8]  = req_idx_a[k];
        end
    endtask

    // pv: chance a idle requester raises a request, pr: consumer ready chance, pu: upload chance (percent).
    task automatic applyStimulus(input int pv, input int pr, input int pu);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!req_vld[k] && ($urandom_range(99) < pv)) begin
                req_vld[k]   = 1'b1;
                req_idx_a[k] = 8'($urandom);
            end
        end
        packInputs();
        i_rsp_ready   = ($urandom_range(99) < pr);
        i_upload_busy = ($urandom_range(99) < pu);
    endtask

    // One cycle, entered and left on a falling edge.
    task automatic stepCycle(input int pv, input int pr, input int pu);
        int            credits, exp_id;
        logic [63:0]   exp_ready;
        logic [2047:0] exp_data;
        bit            do_pop;
        applyStimulus(pv, pr, pu);
        #1;
        credits = RSP_DEPTH - m_fl.size() - m_rsp.size();
        exp_id  = -1;
        if (!i_upload_busy && credits > 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (exp_id < 0 && req_vld[(m_ptr + i) % NUM_REQ]) exp_id = (m_ptr + i) % NUM_REQ;
            end
        end
        exp_ready = (exp_id >= 0) ? (64'd1 << exp_id) : 64'd0;
        checkOutput("req_ready", 64'(o_req_ready), exp_ready);
        checkOutput("tex_idx", 64'(o_tex_idx), 64'(m_last_idx));
        checkOutput("rsp_valid", 64'(o_rsp_valid), 64'(m_rsp.size() != 0));
        checkOutput("busy", 64'(o_busy), 64'((m_fl.size() + m_rsp.size()) != 0));
        if (m_rsp.size() != 0) begin
            exp_data = {256{m_rsp[0].idx}};
            checkOutput("rsp_id", 64'(o_rsp_id), 64'(m_rsp[0].id));
            checkOutput("rsp_data_lo", o_rsp_data[63:0], exp_data[63:0]);
            checkOutput("rsp_data_all", 64'(o_rsp_data == exp_data), 64'd1);
        end
        do_pop = (m_rsp.size() != 0) && i_rsp_ready;
        if ((|i_req_valid) && exp_id < 0) m_stalls++;
        @(posedge clk);
        cyc++;
        if (do_pop) void'(m_rsp.pop_front());
        if (exp_id >= 0) begin
            m_fl.push_back('{id: exp_id, idx: req_idx_a[exp_id], due: cyc + READ_LATENCY});
            m_ptr           = (exp_id + 1) % NUM_REQ;
            m_last_idx      = req_idx_a[exp_id];
            req_vld[exp_id] = 1'b0;
            m_grants++;
        end
        while (m_fl.size() != 0 && m_fl[0].due == cyc) begin
            m_rsp.push_back('{id: m_fl[0].id, idx: m_fl[0].idx});
            void'(m_fl.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic runCycles(input int n, input int pv, input int pr, input int pu);
        for (int c = 0; c < n; c++) stepCycle(pv, pr, pu);
    endtask

    initial begin
        cyc = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_vld[k]   = 1'b0;
            req_idx_a[k] = 8'h00;
        end
        rst_n         = 1'b0;
        i_req_valid   = '1;
        i_req_idx     = '0;
        i_upload_busy = 1'b0;
        i_rsp_ready   = 1'b1;
        #12;
        checkOutput("rst_req_ready", 64'(o_req_ready), 64'd0);
        checkOutput("rst_tex_idx", 64'(o_tex_idx), 64'd0);
        checkOutput("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        checkOutput("rst_rsp_id", 64'(o_rsp_id), 64'd0);
        checkOutput("rst_rsp_data", o_rsp_data[63:0], 64'd0);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();

        // Lone request from requester 2.
        req_vld[2]   = 1'b1;
        req_idx_a[2] = 8'h15;
        runCycles(6, 0, 100, 0);

        // All requesters held valid, consumer always ready.
        runCycles(24, 100, 100, 0);

        // Backpressure, then release.
        runCycles(12, 100, 0, 0);
        runCycles(20, 100, 100, 0);

        // Upload freeze with reads in flight.
        runCycles(10, 0, 100, 0);
        runCycles(2, 100, 100, 0);
        runCycles(8, 100, 100, 100);
        runCycles(6, 100, 100, 0);

        // Random traffic.
        runCycles(1500, 40, 60, 10);
        runCycles(300, 90, 30, 5);

        // Reset one cycle after a grant.
        runCycles(20, 0, 100, 0);
        req_vld[3]   = 1'b1;
        req_idx_a[3] = 8'hA5;
        stepCycle(0, 100, 0);
        req_vld[1]   = 1'b1;
        req_idx_a[1] = 8'h3C;
        req_vld[3]   = 1'b1;
        req_idx_a[3] = 8'h5A;
        packInputs();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        checkOutput("mid_rst_busy", 64'(o_busy), 64'd0);
        checkOutput("mid_rst_req_ready", 64'(o_req_ready), 64'd0);
        checkOutput("mid_rst_tex_idx", 64'(o_tex_idx), 64'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        runCycles(12, 0, 100, 0);

        // Counter scenario: grants followed by credit stalls with the consumer blocked.
        runCycles(8, 100, 100, 0);
        runCycles(6, 100, 0, 0);
        runCycles(10, 0, 100, 0);

`ifdef TEX_ARB_STATS_EN
        checkOutput("grant_cnt", 64'(o_grant_cnt), 64'(m_grants));
        checkOutput("stall_cnt", 64'(o_stall_cnt), 64'(m_stalls));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
